// File: rtl/mem_req_pkg.sv
// Shared types and default sizes for the memory request unit and its watchdog.
package mem_req_pkg;

   localparam int ADDR_W_DEFAULT  = 32;
   localparam int DATA_W_DEFAULT  = 32;
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_req_state_e;

   // Watchdog counter is never narrower than 8 bits, wider only if the limit needs it.
   function automatic int wd_cnt_width(input int limit);
      return (limit > 255) ? $clog2(limit + 1) : 8;
   endfunction

endpackage

// File: rtl/mem_req_watchdog.sv
// Cycle watchdog: clears on request start, counts while enabled, flags the cycle whose count reaches LIMIT.
module mem_req_watchdog #(
   parameter int LIMIT = 255,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CNT_W:0] LIMIT_V = (CNT_W + 1)'(LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;

   assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc[CNT_W-1:0];
      end
   end

   // Flag when the increment about to happen reaches the limit, so the abort lands on that edge.
   assign expired = en && (cnt_inc == LIMIT_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_req_unit.sv
// Single-outstanding memory request unit between the core memory port and a valid/ready external memory.
// Define MEM_REQ_TIMEOUT_EN to add the request/response watchdog.
//
//   state | meaning
//   IDLE  | waiting for core_req; misaligned requests complete here with an error
//   REQ   | m_valid high, address/data held until m_ready
//   RESP  | read accepted, waiting for m_rvalid
module mem_req_unit
   import mem_req_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int DATA_W  = DATA_W_DEFAULT
`ifdef MEM_REQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_done,
   output logic              core_err,
   output logic              core_busy,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata
);

   mem_req_state_e state_q, state_d;

   logic              we_q, we_d;
   logic [ADDR_W-1:2] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic accept;
   logic misalign;
   logic start;
   logic req_hs;
   logic rd_done;
   logic timeout_hit;
   logic abort;

   assign accept   = (state_q == IDLE) && core_req;
   assign misalign = (core_addr[1:0] != 2'b00);
   assign start    = accept && !misalign;
   assign req_hs   = (state_q == REQ) && m_ready;
   assign rd_done  = (state_q == RESP) && m_rvalid;

`ifdef MEM_REQ_TIMEOUT_EN
   mem_req_watchdog #(
      .LIMIT (TIMEOUT),
      .CNT_W (wd_cnt_width(TIMEOUT))
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (reset),
      .clr     (start),
      .en      (state_q != IDLE),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // A handshake or response landing on the expiry cycle still completes normally.
   assign abort = timeout_hit && !req_hs && !rd_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = REQ;
         end
         REQ: begin
            if (req_hs)     state_d = we_q ? IDLE : RESP;
            else if (abort) state_d = IDLE;
         end
         RESP: begin
            if (rd_done || abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_valid   = 1'b0;
      core_busy = 1'b0;
      if (state_q == REQ)  m_valid   = 1'b1;
      if (state_q != IDLE) core_busy = 1'b1;
   end

   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         we_d    = core_we;
         addr_d  = core_addr[ADDR_W-1:2];
         wdata_d = core_wdata;
      end
      if (rd_done) rdata_d = m_rdata;
      done_d = (accept && misalign) || (req_hs && we_q) || rd_done || abort;
      err_d  = (accept && misalign) || abort;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign m_we       = we_q;
   assign m_addr     = {addr_q, 2'b00};
   assign m_wdata    = wdata_q;
   assign core_rdata = rdata_q;
   assign core_done  = done_q;
   assign core_err   = err_q;

endmodule
